// File: rtl/mux32_rr_arbiter_if.sv
// mux32_rr_arbiter_if: bus between the round-robin arbiter, its 32 requesters and the consumer
//   req   [31:0] request per requester (bit i = mux input Ii)
//   ready        downstream accepts the current beat
//   sel   [4:0]  registered mux select
//   grant [31:0] registered one-hot owner, zero when idle
//   valid        current mux output beat is valid
//   ack   [31:0] one-cycle pulse to the owner per accepted beat
//   busy         a grant is held
// master = arbiter side, slave = requesters/consumer side.
interface mux32_rr_arbiter_if;
    logic [31:0] req;
    logic        ready;
    logic [4:0]  sel;
    logic [31:0] grant;
    logic        valid;
    logic [31:0] ack;
    logic        busy;
    modport master (input req, ready, output sel, grant, valid, ack, busy);
    modport slave (output req, ready, input sel, grant, valid, ack, busy);
endinterface

// File: rtl/mux32_rr_arbiter.sv
// mux32_rr_arbiter: round-robin, burst-capped arbiter driving the select of a 32-input 8-bit mux
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   bus.req      request per requester
//   bus.ready    downstream accepts current beat
//   bus.sel      registered mux select
//   bus.grant    registered one-hot owner
//   bus.valid    req of the owner while a grant is held
//   bus.ack      grant while a beat is accepted
//   bus.busy     a grant is held
module mux32_rr_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 3
) (
    input logic                 clk,
    input logic                 rst_n,
    mux32_rr_arbiter_if.master  bus
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state, state_nx;
    logic [4:0]         ptr, ptr_nx, sel, sel_nx;
    logic [31:0]        grant, grant_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic               accept, last, rel;
    logic [5:0]         w_idle, w_rel;

    // First set bit of r searching base, base+1, ... modulo 32; bit 5 flags a winner.
    // Walking downward lets the lowest offset overwrite the others.
    function automatic logic [5:0] pick(input logic [31:0] r, input logic [4:0] base);
        logic [5:0] w;
        logic [4:0] k;
        w = '0;
        for (int i = 31; i >= 0; i--) begin
            k = base + 5'(i);
            if (r[k]) w = {1'b1, k};
        end
        return w;
    endfunction

    assign accept = (state == GRANT) && bus.req[sel] && bus.ready;
    assign last   = cnt == CNT_W'(MAX_BURST - 1);
    // A withdrawn request releases without an ack; a final accepted beat releases with one.
    assign rel    = (state == GRANT) && (!bus.req[sel] || (accept && last));
    assign w_idle = pick(bus.req, ptr);
    // Grant is one-hot of sel in GRANT, so this masks the releasing owner.
    assign w_rel  = pick(bus.req & ~grant, sel + 5'd1);

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        sel_nx   = sel;
        grant_nx = grant;
        cnt_nx   = cnt;
        if (state == IDLE) begin
            if (w_idle[5]) begin
                state_nx = GRANT;
                sel_nx   = w_idle[4:0];
                grant_nx = 32'd1 << w_idle[4:0];
                cnt_nx   = '0;
            end
        end else if (rel) begin
            ptr_nx = sel + 5'd1;
            cnt_nx = '0;
            if (w_rel[5]) begin
                sel_nx   = w_rel[4:0];
                grant_nx = 32'd1 << w_rel[4:0];
            end else if (!bus.req[sel]) begin
                state_nx = IDLE;
                grant_nx = '0;
            end
        end else if (accept) begin
            cnt_nx = cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            sel   <= '0;
            grant <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
            sel   <= sel_nx;
            grant <= grant_nx;
            cnt   <= cnt_nx;
        end
    end

    // State resets asynchronously, so valid and ack drop the moment rst_n falls.
    assign bus.valid = (state == GRANT) && bus.req[sel];
    assign bus.ack   = accept ? grant : '0;
    assign bus.busy  = state == GRANT;
    assign bus.sel   = sel;
    assign bus.grant = grant;
endmodule

// File: tb/tb_mux32_rr_arbiter.sv
// tb_mux32_rr_arbiter: directed scenarios with an ack scoreboard for burst 4 and burst 1 arbiters
module tb_mux32_rr_arbiter;
    logic clk;
    logic rst_n;
    int total = 0;
    int bad = 0;
    int q0[$];
    int q1[$];
    bit [5:0] rpat = 6'b111001;

    mux32_rr_arbiter_if b0();
    mux32_rr_arbiter_if b1();

    mux32_rr_arbiter #(.MAX_BURST(4), .CNT_W(3)) dut (.clk(clk), .rst_n(rst_n), .bus(b0));
    mux32_rr_arbiter #(.MAX_BURST(1), .CNT_W(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Every ack pulse must match the next expected owner index.
    task automatic sb();
        int e;
        if (b0.ack !== '0) begin
            if (q0.size() == 0) chk("ack0_unexpected", b0.ack, 32'd0);
            else begin
                e = q0.pop_front();
                chk("ack0", b0.ack, 32'd1 << e);
            end
        end
        if (b1.ack !== '0) begin
            if (q1.size() == 0) chk("ack1_unexpected", b1.ack, 32'd0);
            else begin
                e = q1.pop_front();
                chk("ack1", b1.ack, 32'd1 << e);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
        sb();
    endtask

    task automatic cycle();
        tick();
        look();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        b0.req = '0;
        b0.ready = 1'b0;
        b1.req = '0;
        b1.ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        b0.req = '0;
        b0.ready = 1'b0;
        b1.req = '0;
        b1.ready = 1'b0;
        tick();
        chk("rst_sel", 32'(b0.sel), 0);
        chk("rst_grant", b0.grant, 0);
        chk("rst_valid", 32'(b0.valid), 0);
        chk("rst_ack", b0.ack, 0);
        chk("rst_busy", 32'(b0.busy), 0);

        // sole requester 2: 4-beat burst, re-granted without a bubble
        rst_n = 1'b1;
        b0.req = 32'h4;
        b0.ready = 1'b1;
        repeat (5) q0.push_back(2);
        look();
        chk("s1_idle_valid", 32'(b0.valid), 0);
        cycle();
        chk("s1_sel", 32'(b0.sel), 2);
        chk("s1_grant", b0.grant, 32'h4);
        chk("s1_valid", 32'(b0.valid), 1);
        chk("s1_busy", 32'(b0.busy), 1);
        repeat (3) cycle();
        cycle();
        chk("s1_ptr", 32'(dut.ptr), 3);
        chk("s1_regrant_sel", 32'(b0.sel), 2);
        chk("s1_regrant_valid", 32'(b0.valid), 1);
        chk("s1_regrant_cnt", 32'(dut.cnt), 0);
        tick();
        b0.req = '0;
        look();
        chk("s1_drop_valid", 32'(b0.valid), 0);
        cycle();
        chk("s1_idle_busy", 32'(b0.busy), 0);
        chk("s1_idle_grant", b0.grant, 0);
        chk("s1_idle_sel_hold", 32'(b0.sel), 2);

        // all requesting: rotation 0..31 then wrap to 0, 4 cycles each
        do_reset();
        b0.req = '1;
        b0.ready = 1'b1;
        for (int o = 0; o < 33; o++) repeat (4) q0.push_back(o % 32);
        look();
        for (int o = 0; o < 33; o++) begin
            for (int bt = 0; bt < 4; bt++) begin
                cycle();
                chk("s2_sel", 32'(b0.sel), 32'(o % 32));
                chk("s2_grant", b0.grant, 32'd1 << (o % 32));
            end
        end
        tick();
        b0.req = '0;
        look();
        chk("s2_drop_valid", 32'(b0.valid), 0);
        cycle();
        chk("s2_idle_busy", 32'(b0.busy), 0);

        // owner 5 with ready pattern 1,0,0,1,1,1
        do_reset();
        b0.req = 32'd1 << 5;
        repeat (4) q0.push_back(5);
        look();
        for (int i = 0; i < 6; i++) begin
            tick();
            b0.ready = rpat[i];
            look();
            chk("s3_sel", 32'(b0.sel), 5);
            chk("s3_valid", 32'(b0.valid), 1);
            if (i == 2) chk("s3_cnt_stall", 32'(dut.cnt), 1);
        end
        tick();
        b0.req = '0;
        look();
        chk("s3_drop_valid", 32'(b0.valid), 0);
        cycle();
        chk("s3_idle_busy", 32'(b0.busy), 0);

        // owners 7 and 9; 7 withdraws after 2 beats
        do_reset();
        b0.req = (32'd1 << 7) | (32'd1 << 9);
        b0.ready = 1'b1;
        q0.push_back(7);
        q0.push_back(7);
        q0.push_back(9);
        look();
        cycle();
        chk("s4_sel7", 32'(b0.sel), 7);
        cycle();
        tick();
        b0.req = 32'd1 << 9;
        look();
        chk("s4_drop_valid", 32'(b0.valid), 0);
        chk("s4_drop_ack", b0.ack, 0);
        chk("s4_drop_sel", 32'(b0.sel), 7);
        cycle();
        chk("s4_sel9", 32'(b0.sel), 9);
        chk("s4_cnt9", 32'(dut.cnt), 0);
        chk("s4_valid9", 32'(b0.valid), 1);
        tick();
        b0.req = '0;
        look();
        cycle();
        chk("s4_idle_busy", 32'(b0.busy), 0);

        // async reset mid-burst of owner 12, then a fresh burst
        do_reset();
        b0.req = 32'h1000;
        b0.ready = 1'b1;
        repeat (2) q0.push_back(12);
        look();
        cycle();
        cycle();
        tick();
        #1;
        chk("s5_cnt_before", 32'(dut.cnt), 2);
        chk("s5_valid_before", 32'(b0.valid), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("s5_rst_valid", 32'(b0.valid), 0);
        chk("s5_rst_ack", b0.ack, 0);
        chk("s5_rst_grant", b0.grant, 0);
        chk("s5_rst_sel", 32'(b0.sel), 0);
        chk("s5_rst_busy", 32'(b0.busy), 0);
        chk("s5_rst_cnt", 32'(dut.cnt), 0);
        look();
        tick();
        rst_n = 1'b1;
        repeat (4) q0.push_back(12);
        look();
        chk("s5_idle_valid", 32'(b0.valid), 0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("s5_sel", 32'(b0.sel), 12);
            chk("s5_cnt", 32'(dut.cnt), 32'(i));
        end
        tick();
        b0.req = '0;
        look();
        cycle();
        chk("s5_idle_busy", 32'(b0.busy), 0);

        // burst of 1: owners 0 and 31 alternate every beat
        do_reset();
        b1.req = 32'h8000_0001;
        b1.ready = 1'b1;
        for (int k = 0; k < 6; k++) q1.push_back((k % 2 == 1) ? 31 : 0);
        look();
        for (int k = 0; k < 6; k++) begin
            cycle();
            chk("s6_sel", 32'(b1.sel), (k % 2 == 1) ? 32'd31 : 32'd0);
            chk("s6_grant", b1.grant, (k % 2 == 1) ? 32'h8000_0000 : 32'h1);
        end
        tick();
        b1.req = '0;
        look();
        cycle();
        chk("s6_idle_busy", 32'(b1.busy), 0);

        chk("q0_left", 32'(q0.size()), 0);
        chk("q1_left", 32'(q1.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
